// File: rtl/text_mode_renderer_if.sv
`default_nettype none
//============================================================================
// Module   : text_mode_renderer_if
// Desc     : Char RAM / font ROM fetch bus between renderer and memories.
// Revision : 1.0
//============================================================================
interface text_mode_renderer_if;
    logic [11:0] char_addr;
    logic [15:0] char_data;
    logic [11:0] font_addr;
    logic [7:0]  font_data;

    modport master (
        output char_addr,
        output font_addr,
        input  char_data,
        input  font_data
    );

    modport slave (
        input  char_addr,
        input  font_addr,
        output char_data,
        output font_data
    );
endinterface
`default_nettype wire

// File: rtl/text_mode_renderer.sv
`default_nettype none
//============================================================================
// Module   : text_mode_renderer
// Desc     : Character-cell text renderer, 5-cycle pipeline, blinking cursor.
// Revision : 1.0
//============================================================================
module text_mode_renderer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int CHAR_W     = 8,
    parameter int CHAR_H     = 16,
    parameter int BLINK_LOG2 = 5
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic [9:0]  hpos,
    input  wire logic [9:0]  vpos,
    input  wire logic        display_on,
    input  wire logic        hsync,
    input  wire logic        vsync,
    input  wire logic        cursor_en,
    input  wire logic [6:0]  cursor_col,
    input  wire logic [4:0]  cursor_row,
    text_mode_renderer_if.master mem,
    output logic [3:0]       pixel_color,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             display_on_out
);

    localparam int LATENCY  = 5;
    localparam int c_COL_SH = $clog2(CHAR_W);
    localparam int c_ROW_SH = $clog2(CHAR_H);

    logic [6:0]  w_cell_col;
    logic [5:0]  w_cell_row;
    logic [2:0]  w_col_lo;
    logic [3:0]  w_row_lo;
    logic [11:0] w_char_addr;
    logic        w_cursor_match;
    logic        w_blink;
    logic        w_bit;

    // Side-band {display_on, hsync, vsync} travels through the full latency.
    logic [2:0]  r_side [LATENCY];

    logic [11:0] r_char_addr;
    logic [2:0]  r_col_lo1, r_col_lo2, r_col_lo3, r_col_lo4;
    logic [3:0]  r_row_lo1, r_row_lo2;
    logic        r_match1, r_match2;
    logic [11:0] r_font_addr;
    logic [3:0]  r_fg3, r_bg3, r_fg4, r_bg4;
    logic        r_cur_hit3, r_cur_hit4;
    logic [3:0]  r_pixel_color;
    logic        r_vsync_prev;
    logic [BLINK_LOG2-1:0] r_frame_cnt;

    always_comb begin
        w_cell_col  = 7'(hpos >> c_COL_SH);
        w_cell_row  = 6'(vpos >> c_ROW_SH);
        w_col_lo    = hpos[2:0];
        w_row_lo    = vpos[3:0];
        w_char_addr = 12'(w_cell_row) * 12'(COLS) + 12'(w_cell_col);
        // Out-of-grid cursor coordinates must never light a cell.
        w_cursor_match = cursor_en
                       && (cursor_col < 7'(COLS))
                       && (cursor_row < 5'(ROWS))
                       && (w_cell_col == cursor_col)
                       && (w_cell_row == {1'b0, cursor_row})
                       && (w_row_lo >= 4'(CHAR_H - 2));
        w_blink = r_frame_cnt[BLINK_LOG2-1];
        w_bit   = mem.font_data[3'd7 - r_col_lo4] ^ r_cur_hit4;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_side[i] <= 3'b000;
            end
            r_char_addr   <= '0;
            r_col_lo1     <= '0;
            r_col_lo2     <= '0;
            r_col_lo3     <= '0;
            r_col_lo4     <= '0;
            r_row_lo1     <= '0;
            r_row_lo2     <= '0;
            r_match1      <= 1'b0;
            r_match2      <= 1'b0;
            r_font_addr   <= '0;
            r_fg3         <= '0;
            r_bg3         <= '0;
            r_fg4         <= '0;
            r_bg4         <= '0;
            r_cur_hit3    <= 1'b0;
            r_cur_hit4    <= 1'b0;
            r_pixel_color <= '0;
            r_vsync_prev  <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_side[0] <= {display_on, hsync, vsync};
            for (int i = 1; i < LATENCY; i++) begin
                r_side[i] <= r_side[i-1];
            end

            // E1: address generation and per-pixel sideband capture
            r_char_addr <= display_on ? w_char_addr : 12'd0;
            r_col_lo1   <= w_col_lo;
            r_row_lo1   <= w_row_lo;
            r_match1    <= w_cursor_match;

            // E2: char RAM is reading
            r_col_lo2 <= r_col_lo1;
            r_row_lo2 <= r_row_lo1;
            r_match2  <= r_match1;

            // E3: char word available, issue glyph fetch
            r_font_addr <= {mem.char_data[7:0], r_row_lo2};
            r_fg3       <= mem.char_data[11:8];
            r_bg3       <= mem.char_data[15:12];
            r_cur_hit3  <= r_match2 & w_blink;
            r_col_lo3   <= r_col_lo2;

            // E4: font ROM is reading
            r_fg4      <= r_fg3;
            r_bg4      <= r_bg3;
            r_cur_hit4 <= r_cur_hit3;
            r_col_lo4  <= r_col_lo3;

            // E5: colour select
            if (r_side[LATENCY-2][2]) begin
                r_pixel_color <= w_bit ? r_fg4 : r_bg4;
            end else begin
                r_pixel_color <= 4'd0;
            end

            r_vsync_prev <= vsync;
            if (vsync && !r_vsync_prev) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign mem.char_addr  = r_char_addr;
    assign mem.font_addr  = r_font_addr;
    assign pixel_color    = r_pixel_color;
    assign display_on_out = r_side[LATENCY-1][2];
    assign hsync_out      = r_side[LATENCY-1][1];
    assign vsync_out      = r_side[LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_text_mode_renderer.sv
`default_nettype none
//============================================================================
// Module   : tb_text_mode_renderer
// Desc     : Scoreboard bench for text_mode_renderer with directed vectors.
// Revision : 1.0
//============================================================================
module tb_text_mode_renderer;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos, vpos;
    logic       display_on, hsync, vsync, cursor_en;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic [3:0] pixel_color;
    logic       hsync_out, vsync_out, display_on_out;

    text_mode_renderer_if mem();

    text_mode_renderer dut (
        .clk            (clk),
        .reset          (reset),
        .hpos           (hpos),
        .vpos           (vpos),
        .display_on     (display_on),
        .hsync          (hsync),
        .vsync          (vsync),
        .cursor_en      (cursor_en),
        .cursor_col     (cursor_col),
        .cursor_row     (cursor_row),
        .mem            (mem),
        .pixel_color    (pixel_color),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .display_on_out (display_on_out)
    );

    always #5 clk = ~clk;

    // Address 0 and glyph code 0x5C hold distinct content so stale or ungated data shows up.
    logic [15:0] char_ram_val = 16'h1F41;
    logic [7:0]  font_rom_val = 8'h81;
    always @(posedge clk) begin
        mem.char_data <= (mem.char_addr == 12'd0) ? 16'h9A5C : char_ram_val;
        mem.font_data <= (mem.font_addr[11:4] == 8'h5C) ? 8'hFF : font_rom_val;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit in_reset = 1'b1;

    typedef struct {
        int          due;
        int          kind;
        logic [11:0] val;
        logic        hs;
        logic        vs;
        logic        de;
    } exp_t;
    exp_t sb[$];

    task automatic push(input int due, input int kind, input logic [11:0] val,
                        input logic hs, input logic vs, input logic de);
        exp_t e;
        e.due = due; e.kind = kind; e.val = val; e.hs = hs; e.vs = vs; e.de = de;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!in_reset) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due < cyc) begin
                    total++; bad++;
                    $display("FAIL missed: entry due %0d not checked (now %0d)", sb[i].due, cyc);
                    sb.delete(i);
                end else if (sb[i].due == cyc) begin
                    total++;
                    if (sb[i].kind == 0) begin
                        if ({pixel_color, hsync_out, vsync_out, display_on_out} !==
                            {sb[i].val[3:0], sb[i].hs, sb[i].vs, sb[i].de}) begin
                            bad++;
                            $display("FAIL pixel@%0d: got color=%h hs=%b vs=%b de=%b want color=%h hs=%b vs=%b de=%b",
                                     cyc, pixel_color, hsync_out, vsync_out, display_on_out,
                                     sb[i].val[3:0], sb[i].hs, sb[i].vs, sb[i].de);
                        end
                    end else if (sb[i].kind == 1) begin
                        if (mem.char_addr !== sb[i].val) begin
                            bad++;
                            $display("FAIL char_addr@%0d: got %0d want %0d", cyc, mem.char_addr, sb[i].val);
                        end
                    end else begin
                        if (mem.font_addr !== sb[i].val) begin
                            bad++;
                            $display("FAIL font_addr@%0d: got %h want %h", cyc, mem.font_addr, sb[i].val);
                        end
                    end
                    sb.delete(i);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic de, input logic hs,
                         input logic vs, input logic [3:0] col);
        @(negedge clk);
        hpos = 10'(h); vpos = 10'(v);
        display_on = de; hsync = hs; vsync = vs;
        push(cyc + 5, 0, {8'h00, col}, hs, vs, de);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 1'b0, 1'b0, 1'b0, 4'h0);
    endtask

    task automatic vs_pulses(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 1'b0, 1'b0, 1'b1, 4'h0);
            drive(0, 0, 1'b0, 1'b0, 1'b0, 4'h0);
        end
    endtask

    initial begin
        reset = 1'b0;
        hpos = '0; vpos = '0; display_on = 1'b0; hsync = 1'b0; vsync = 1'b0;
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_color", 16'(pixel_color), 16'h0);
        chk("rst_hs", 16'(hsync_out), 16'h0);
        chk("rst_vs", 16'(vsync_out), 16'h0);
        chk("rst_de", 16'(display_on_out), 16'h0);
        chk("rst_char_addr", 16'(mem.char_addr), 16'h0);
        chk("rst_font_addr", 16'(mem.font_addr), 16'h0);
        @(negedge clk);
        reset = 1'b1; in_reset = 1'b0;
        idle(2);

        // single-cycle sideband pulses
        drive(0, 0, 1'b0, 1'b1, 1'b0, 4'h0);  idle(6);
        drive(0, 0, 1'b0, 1'b0, 1'b1, 4'h0);  idle(6);
        drive(16, 35, 1'b1, 1'b0, 1'b0, 4'hF); idle(6);

        // addressing: cell (2,2), row 3 of glyph 'A'
        drive(17, 35, 1'b1, 1'b0, 1'b0, 4'h1);
        push(cyc + 1, 1, 12'd162, 1'b0, 1'b0, 1'b0);
        push(cyc + 3, 2, 12'h413, 1'b0, 1'b0, 1'b0);
        idle(6);

        // glyph row 0x81 across one cell
        for (int i = 0; i < 8; i++)
            drive(16 + i, 35, 1'b1, 1'b0, 1'b0, (i == 0 || i == 7) ? 4'hF : 4'h1);
        idle(6);

        // blanking with hsync passing through
        drive(17, 35, 1'b0, 1'b1, 1'b0, 4'h0);
        push(cyc + 1, 1, 12'd0, 1'b0, 1'b0, 1'b0);
        drive(16, 35, 1'b0, 1'b0, 1'b0, 4'h0);
        idle(6);

        // last cell of the grid
        drive(639, 479, 1'b1, 1'b0, 1'b0, 4'hF);
        push(cyc + 1, 1, 12'd2399, 1'b0, 1'b0, 1'b0);
        idle(6);

        // asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) drive(16, 35, 1'b1, 1'b1, 1'b0, 4'hF);
        @(negedge clk);
        #2 reset = 1'b0; in_reset = 1'b1;
        #1;
        chk("mid_rst_color", 16'(pixel_color), 16'h0);
        chk("mid_rst_hs", 16'(hsync_out), 16'h0);
        chk("mid_rst_de", 16'(display_on_out), 16'h0);
        chk("mid_rst_char_addr", 16'(mem.char_addr), 16'h0);
        chk("mid_rst_font_addr", 16'(mem.font_addr), 16'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1; in_reset = 1'b0;
        hpos = 10'd16; vpos = 10'd35; display_on = 1'b1; hsync = 1'b1; vsync = 1'b0;
        push(cyc + 5, 0, 12'hF, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 5; k++) push(cyc + k, 0, 12'h0, 1'b0, 1'b0, 1'b0);
        drive(23, 35, 1'b1, 1'b0, 1'b0, 4'hF);
        idle(6);

        // cursor blink at cell (2,2), blank glyph
        font_rom_val = 8'h00;
        cursor_en = 1'b1; cursor_col = 7'd2; cursor_row = 5'd2;
        idle(4);
        vs_pulses(15); idle(2);
        drive(16, 46, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(16, 47, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(2);
        vs_pulses(1); idle(2);
        drive(16, 46, 1'b1, 1'b0, 1'b0, 4'hF);
        drive(23, 47, 1'b1, 1'b0, 1'b0, 4'hF);
        drive(16, 45, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(16, 32, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(24, 46, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(16, 30, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(1); cursor_col = 7'd82;
        drive(656, 46, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(1); cursor_col = 7'd2; cursor_row = 5'd31;
        drive(16, 510, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(1); cursor_row = 5'd2; cursor_en = 1'b0;
        drive(16, 46, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(1); cursor_en = 1'b1;
        vs_pulses(16); idle(2);
        drive(16, 46, 1'b1, 1'b0, 1'b0, 4'h1);
        drive(16, 47, 1'b1, 1'b0, 1'b0, 4'h1);
        idle(8);

        for (int k = 0; k < 50 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/text_mode_renderer.md
Name: text_mode_renderer

Overview:
- Character-cell text renderer that sits directly downstream of the video timing generator.
- Consumes hpos/vpos/display_on/hsync/vsync, fetches character+attribute words from an external synchronous char RAM and glyph rows from an external synchronous font ROM, and emits a 4-bit colour index per pixel.
- Delays sync and display_on by the full pipeline latency so they stay aligned with pixel_color.
- Provides a blinking underline cursor.

Parameters:
- COLS, 80, character columns per row
- ROWS, 30, character rows per frame
- CHAR_W, 8, pixel width of a cell (fixed power of two; hpos>>3)
- CHAR_H, 16, pixel height of a cell (fixed power of two; vpos>>4)
- BLINK_LOG2, 5, width of frame counter; cursor phase = frame_cnt[BLINK_LOG2-1]
- LATENCY, 5, input-to-output pipeline depth (informational, not overridable)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  10  horizontal position from timing generator
- vpos  in  10  vertical position from timing generator
- display_on  in  1  visible-area flag
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- cursor_en  in  1  enable cursor
- cursor_col  in  7  cursor cell column
- cursor_row  in  5  cursor cell row
- char_addr  out  12  char RAM address, registered
- char_data  in  16  [7:0] code, [11:8] fg, [15:12] bg; valid one cycle after char_addr
- font_addr  out  12  {code[7:0], glyph_row[3:0]}, registered
- font_data  in  8  glyph row, bit7 = leftmost pixel; valid one cycle after font_addr
- pixel_color  out  4  colour index
- hsync_out  out  1  hsync delayed LATENCY cycles
- vsync_out  out  1  vsync delayed LATENCY cycles
- display_on_out  out  1  display_on delayed LATENCY cycles

Behaviour:
- Reset (reset=0, async): every register and output = 0, including char_addr, font_addr, pixel_color, sync outputs, frame_cnt, and all pipeline stages. Takes effect mid-line without waiting for clk.
- Edge E1 (input cycle t):
  - char_addr <= display_on ? (vpos>>4)*COLS + (hpos>>3) : 0. Max value 2399; 12-bit result, no overflow.
  - Pipeline col_lo=hpos[2:0], row_lo=vpos[3:0], cell col/row, display_on, hsync, vsync.
- RAM registers char_addr at E2; char_data valid between E2 and E3.
- Edge E3:
  - font_addr <= {char_data[7:0], row_lo}.
  - Latch fg/bg.
  - cur_hit <= cursor_en & blink & cell==cursor & row_lo>=CHAR_H-2 (underline rows 14,15).
- ROM registers at E4; font_data valid between E4 and E5.
- Edge E5 outputs:
  - bit = font_data[7-col_lo] ^ cur_hit.
  - pixel_color <= display_on_d ? (bit ? fg : bg) : 0.
  - Delayed sync/display_on outputs.
- Latency: exactly 5 clk edges from any input to the corresponding output. All side signals travel in a 5-deep shift pipeline alongside the data.
- Blink:
  - vsync rising edge is detected on the input (registered previous value).
  - frame_cnt increments on each rising edge and wraps 2^BLINK_LOG2-1 -> 0.
  - blink = frame_cnt[BLINK_LOG2-1]; with the default, the cursor is on for 16 frames and off for 16 frames.
- Cursor: a cursor_col/cursor_row outside the grid never matches, so no cursor is drawn. Cursor inputs are sampled at E1 with the pixel.
- Blanking: display_on=0 forces char_addr=0 and, 5 cycles later, pixel_color=0. Sync outputs pass through unchanged.
- Continuous streaming: no stalls and no handshake. A new pixel is accepted every cycle.
- After reset release, outputs are meaningful from the 5th edge onward. Before that, pipeline zeros are emitted (colour 0, syncs low).

Test Plan:
- Reset: stream active, drive reset=0 between edges -> all outputs 0 immediately and frame_cnt=0; release -> first valid pixel exactly 5 edges later.
- Latency/alignment: single-cycle hsync=1 at cycle t -> hsync_out=1 only at t+5. Same check for vsync and display_on.
- Addressing: hpos=17, vpos=35, display_on=1 -> char_addr=162 after E1. With char_data=0x1F41, font_addr=0x413 after E3.
- Pixel path: char_data=0x1F41 (fg=F, bg=1), font_data=0x81, hpos 16..23 -> pixel_color F,1,1,1,1,1,1,F at t+5..t+12.
- Blanking: display_on=0 with nonzero font_data -> char_addr=0 and pixel_color=0 five cycles later.
- Cursor blink: cursor_en=1, cursor at (2,2), font_data=0x00, fg=F, bg=1.
  - 15 vsync rising edges -> rows 14/15 of the cell show colour 1.
  - After the 16th edge -> rows 14/15 of the cell show F; rows 0..13 of the cell stay 1.
  - After the 32nd edge -> rows 14/15 show 1 again (counter wrap).
